// File: rtl/lsu_ctrl.sv
// Load/store control stage: turns an execute-stage memory instruction into one
// valid/ready data-bus transaction and returns the extended load result.
module lsu_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic             req_write,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] rdata,
  output logic             misalign,
  output logic             fault,
  output logic             mem_valid,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic {IDLE, BUS} state_e;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   byte_en = 4'b0001 << off;
      2'b01:   byte_en = 4'b0011 << off;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   lane_data = {4{d[7:0]}};
      2'b01:   lane_data = {2{d[15:0]}};
      default: lane_data = d;
    endcase
  endfunction

  // funct3[2] selects zero extension; funct3[1:0] selects access size.
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (f3[1:0])
      2'b00:   load_ext = f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   load_ext = f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: load_ext = w;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic        done_q, done_d, misalign_q, misalign_d, fault_q, fault_d;
  logic        mem_valid_q, mem_valid_d, mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        legal, misal;

  assign legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (!req_write && ((funct3 == 3'b100) || (funct3 == 3'b101)));
  assign misal = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    misalign_d  = 1'b0;
    fault_d     = 1'b0;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    f3_d        = f3_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        // The completion pulse cycle is excluded so the same instruction is not reissued.
        if (req_valid && !(done_q || misalign_q || fault_q)) begin
          if (!legal) begin
            fault_d = 1'b1;
          end else if (misal) begin
            misalign_d = 1'b1;
          end else begin
            state_d     = BUS;
            mem_valid_d = 1'b1;
            mem_we_d    = req_write;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_be_d    = byte_en(funct3[1:0], addr[1:0]);
            mem_wdata_d = req_write ? lane_data(funct3[1:0], wdata) : 32'd0;
            f3_d        = funct3;
            off_d       = addr[1:0];
            cnt_d       = 8'd0;
          end
        end
      end
      BUS: begin
        if (mem_ready) begin
          state_d     = IDLE;
          mem_valid_d = 1'b0;
          done_d      = 1'b1;
          rdata_d     = mem_we_q ? 32'd0 : load_ext(f3_q, off_q, mem_rdata);
          cnt_d       = 8'd0;
        end else if (cnt_q + 8'd1 == TO_LIMIT) begin
          state_d     = IDLE;
          mem_valid_d = 1'b0;
          fault_d     = 1'b1;
          cnt_d       = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
      fault_q     <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
      f3_q        <= 3'd0;
      off_q       <= 2'd0;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      misalign_q  <= misalign_d;
      fault_q     <= fault_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
    end
  end

  assign stall     = req_valid & ~(done_q | misalign_q | fault_q);
  assign done      = done_q;
  assign misalign  = misalign_q;
  assign fault     = fault_q;
  assign rdata     = rdata_q;
  assign mem_valid = mem_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed requests push expected bus and
// response records; a negedge monitor pops and compares them.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, done, misalign, fault;
  logic [31:0] rdata;
  logic        mem_valid, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  lsu_ctrl #(.WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall), .done(done),
    .rdata(rdata), .misalign(misalign), .fault(fault), .mem_valid(mem_valid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] kind; logic [31:0] rdata; } resp_t;
  typedef struct packed { logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic we; } bus_t;

  localparam logic [1:0] K_DONE = 2'd0, K_MIS = 2'd1, K_FLT = 2'd2;

  resp_t resp_q[$];
  bus_t  bus_q[$];
  bus_t  cur;
  resp_t r;
  logic  mv_prev = 1'b0;
  int    vectors = 0;
  int    miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      mv_prev = 1'b0;
    end else begin
      if (done | misalign | fault) begin
        if (resp_q.size() == 0) begin
          chk("unexpected_pulse", 32'd1, 32'd0);
        end else begin
          r = resp_q.pop_front();
          chk("resp_kind", {30'd0, done ? K_DONE : (misalign ? K_MIS : K_FLT)}, {30'd0, r.kind});
          chk("pulse_onehot", $countones({done, misalign, fault}), 32'd1);
          if (done) chk("rdata", rdata, r.rdata);
          chk("stall_in_pulse", {31'd0, stall}, 32'd0);
        end
      end
      if (mem_valid && !mv_prev) begin
        if (bus_q.size() == 0) chk("unexpected_bus", 32'd1, 32'd0);
        else cur = bus_q.pop_front();
      end
      if (mem_valid) begin
        chk("mem_addr", mem_addr, cur.addr);
        chk("mem_be", {28'd0, mem_be}, {28'd0, cur.be});
        chk("mem_wdata", mem_wdata, cur.wdata);
        chk("mem_we", {31'd0, mem_we}, {31'd0, cur.we});
        chk("stall_in_bus", {31'd0, stall}, 32'd1);
      end
      mv_prev = mem_valid;
    end
  end

  // delay = BUS cycles with mem_ready low before it rises; ecyc = expected BUS cycles observed.
  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] word, input int delay,
                        input logic [1:0] kind, input logic [31:0] exp_rd,
                        input logic [3:0] ebe, input logic [31:0] ewd, input int ecyc);
    int  cyc;
    bit  got;
    resp_q.push_back('{kind, exp_rd});
    if (ecyc > 0) bus_q.push_back('{a & ~32'h3, ebe, ewd, w});
    req_valid = 1'b1; req_write = w; funct3 = f3; addr = a; wdata = wd;
    mem_rdata = word; mem_ready = 1'b0;
    #1 chk("stall_on_req", {31'd0, stall}, 32'd1);
    cyc = 0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done | misalign | fault) begin got = 1'b1; break; end
      if (mem_valid) begin
        if (cyc == delay) mem_ready = 1'b1;
        cyc++;
      end
    end
    if (!got) chk("response_timeout", 32'd0, 32'd1);
    mem_ready = 1'b0;
    chk("bus_cycles", cyc, ecyc);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("no_reissue", {31'd0, mem_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; funct3 = 3'd0;
    addr = 32'd0; wdata = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
    #12;
    chk("rst_outputs", {done, misalign, fault, mem_valid, mem_we, stall}, 32'd0);
    chk("rst_data", mem_addr | mem_wdata | rdata | {28'd0, mem_be}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    //     w     f3      addr          wdata          rdata word    dly kind   exp rdata      be     exp wdata     cyc
    do_req(1'b1, 3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0,         0, K_DONE, 32'h0,         4'hF,  32'hDEAD_BEEF, 1);
    do_req(1'b0, 3'b000, 32'h0000_2003, 32'h0,         32'h80FF_0000, 0, K_DONE, 32'hFFFF_FF80, 4'h8,  32'h0,         1);
    do_req(1'b0, 3'b100, 32'h0000_2003, 32'h0,         32'h80FF_0000, 0, K_DONE, 32'h0000_0080, 4'h8,  32'h0,         1);
    do_req(1'b0, 3'b001, 32'h0000_2002, 32'h0,         32'h80FF_0000, 0, K_DONE, 32'hFFFF_80FF, 4'hC,  32'h0,         1);
    do_req(1'b1, 3'b001, 32'h0000_3001, 32'h1234_5678, 32'h0,         0, K_MIS,  32'h0,         4'h0,  32'h0,         0);
    chk("rdata_hold", rdata, 32'hFFFF_80FF);
    do_req(1'b0, 3'b011, 32'h0000_3000, 32'h0,         32'h0,         0, K_FLT,  32'h0,         4'h0,  32'h0,         0);
    do_req(1'b1, 3'b100, 32'h0000_3001, 32'h0,         32'h0,         0, K_FLT,  32'h0,         4'h0,  32'h0,         0);
    do_req(1'b1, 3'b000, 32'h0000_4002, 32'h0000_00A5, 32'h0,         0, K_DONE, 32'h0,         4'h4,  32'hA5A5_A5A5, 1);
    do_req(1'b1, 3'b001, 32'h0000_4002, 32'h1234_BEEF, 32'h0,         0, K_DONE, 32'h0,         4'hC,  32'hBEEF_BEEF, 1);
    do_req(1'b0, 3'b101, 32'h0000_5000, 32'h0,         32'h0000_8001, 0, K_DONE, 32'h0000_8001, 4'h3,  32'h0,         1);
    do_req(1'b0, 3'b001, 32'h0000_5000, 32'h0,         32'h0000_8001, 0, K_DONE, 32'hFFFF_8001, 4'h3,  32'h0,         1);
    do_req(1'b0, 3'b010, 32'h0000_6004, 32'h0,         32'hCAFE_F00D, 4, K_DONE, 32'hCAFE_F00D, 4'hF,  32'h0,         5);
    do_req(1'b0, 3'b010, 32'h0000_7000, 32'h0,         32'h0,       255, K_FLT,  32'h0,         4'hF,  32'h0,         16);
    do_req(1'b0, 3'b010, 32'h0000_7004, 32'h0,         32'h1122_3344, 0, K_DONE, 32'h1122_3344, 4'hF,  32'h0,         1);

    // Abandon a bus transaction with an asynchronous reset between clock edges.
    bus_q.push_back('{32'h0000_7008, 4'hF, 32'h0, 1'b0});
    req_valid = 1'b1; req_write = 1'b0; funct3 = 3'b010; addr = 32'h0000_7008; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_bus_ctrl", {29'd0, mem_valid, done, fault}, 32'd0);
    chk("rst_mid_bus_rdata", rdata, 32'd0);
    chk("rst_mid_bus_addr", mem_addr, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    do_req(1'b0, 3'b010, 32'h0000_8000, 32'h0,         32'h55AA_55AA, 0, K_DONE, 32'h55AA_55AA, 4'hF,  32'h0,         1);

    repeat (2) @(posedge clk);
    chk("resp_q_drained", resp_q.size(), 32'd0);
    chk("bus_q_drained", bus_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
